// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop synchroniser, 3-sample majority vote per bit, valid/ready output handshake.
// Optional parity bit when the macro UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    generate
        if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
            $error("uart_rx_cfg: CLKS_PER_BIT out of range");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
            $error("uart_rx_cfg: DATA_BITS out of range");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
            $error("uart_rx_cfg: STOP_BITS out of range");
        end
        if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_po
            $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    localparam int          H         = CLKS_PER_BIT / 2;
    localparam logic [15:0] SAMP0     = 16'(H - 1);
    localparam logic [15:0] SAMP1     = 16'(H);
    localparam logic [15:0] SAMP2     = 16'(H + 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP
    } state_t;
`endif

    state_t                 state_q;
    logic                   rx_meta_q;
    logic                   rx_sync_q;
    logic                   rx_prev_q;
    logic [15:0]            cyc_q;
    logic [3:0]             bit_q;
    logic [1:0]             samp_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   ferr_acc_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q;
    logic                   parity_err_q;
`endif

    logic vote_d;
    logic at_sample_d;
    logic at_end_d;

    // Third sample is the live synchronised value at offset H+1.
    assign vote_d      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
    assign at_sample_d = (cyc_q == SAMP2);
    assign at_end_d    = (cyc_q == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            cyc_q       <= '0;
            bit_q       <= '0;
            samp_q      <= 2'b11;
            shift_q     <= '0;
            ferr_acc_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            overrun_q <= 1'b0;

            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (state_q != ST_IDLE) begin
                cyc_q <= at_end_d ? 16'd0 : cyc_q + 16'd1;
                if (cyc_q == SAMP0) samp_q[0] <= rx_sync_q;
                if (cyc_q == SAMP1) samp_q[1] <= rx_sync_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q    <= ST_START;
                        cyc_q      <= '0;
                        bit_q      <= '0;
                        ferr_acc_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (at_sample_d && vote_d) begin
                        state_q <= ST_IDLE;
                    end else if (at_end_d) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (at_sample_d) begin
                        shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
                    end
                    if (at_end_d) begin
                        if (bit_q == LAST_DATA) begin
                            bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (at_sample_d) par_bit_q <= vote_d;
                    if (at_end_d)    state_q   <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    // Completion happens at the last stop sample, not at the end of the bit.
                    if (at_sample_d) begin
                        if (bit_q == LAST_STOP) begin
                            state_q     <= ST_IDLE;
                            rx_data_q   <= shift_q;
                            frame_err_q <= ferr_acc_q | ~vote_d;
                            rx_valid_q  <= 1'b1;
                            overrun_q   <= rx_valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= (^shift_q) ^ par_bit_q ^ 1'(PARITY_ODD);
`endif
                        end else begin
                            ferr_acc_q <= ferr_acc_q | ~vote_d;
                        end
                    end
                    if (at_end_d) begin
                        bit_q <= bit_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg at CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1.
module tb_uart_rx_cfg;
    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 5 + (1 + DB + PB) * CPB + H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    uart_rx_cfg #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    int   valid_rises = 0;
    int   handshakes = 0;
    int   overruns = 0;
    int   valid_len = 0;
    int   last_len = 0;
    logic valid_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp_v);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && !valid_prev) begin
                valid_rises++;
                rise_cyc = cyc;
            end
            if (rx_valid) valid_len++;
            else if (valid_prev) begin
                last_len  = valid_len;
                valid_len = 0;
            end
            if (overrun) begin
                overruns++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                else check_eq("spurious_overrun", 1, 0);
            end
            if (rx_valid && rx_ready) begin
                handshakes++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("word data=%02h frame_err=%0b parity_err=%0b (exp %02h %0b %0b)",
                             rx_data, frame_err, parity_err, mon_e.data, mon_e.fe, mon_e.pe);
                    check_eq("rx_data", 32'(rx_data), 32'(mon_e.data));
                    check_eq("frame_err", 32'(frame_err), 32'(mon_e.fe));
                    check_eq("parity_err", 32'(parity_err), 32'(mon_e.pe));
                end
            end
            valid_prev = rx_valid;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_v;
        repeat (CPB) @(negedge clk);
`else
        if (par_v) rx = 1'b1;
`endif
        rx = stop_v;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(rx_valid), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_data"}, 32'(rx_data), 0);
        check_eq({tag, "_ferr"}, 32'(frame_err), 0);
        check_eq({tag, "_perr"}, 32'(parity_err), 0);
        check_eq({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises0;
        int hs0;

        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single word, ready held high
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_drain();
        check_eq("latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        check_eq("valid_len", 32'(last_len), 1);
        check_eq("valid_rises_a5", 32'(valid_rises), 1);

        // False start: 5-cycle low glitch
        rises0 = valid_rises;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("false_start_busy", 32'(busy), 1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("false_start_idle", 32'(busy), 0);
        check_eq("false_start_novalid", 32'(valid_rises - rises0), 0);

        // Framing error then clean word
        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        push_exp(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        wait_drain();

        // Line held low: exactly one word with a framing error
        rises0 = valid_rises;
        push_exp(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        rx = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        check_eq("held_low_idle", 32'(busy), 0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        wait_drain();
        check_eq("held_low_words", 32'(valid_rises - rises0), 1);

        // Overrun with ready low
        @(posedge clk);
        #1 rx_ready = 1'b0;
        hs0 = handshakes;
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        push_exp(8'h22, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check_eq("overrun_count", 32'(overruns), 1);
        check_eq("overrun_valid", 32'(rx_valid), 1);
        check_eq("overrun_data", 32'(rx_data), 32'h22);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("overrun_handshakes", 32'(handshakes - hs0), 1);
        check_eq("overrun_valid_clr", 32'(rx_valid), 0);
        wait_drain();

`ifdef UART_RX_PARITY_EN
        push_exp(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        push_exp(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_drain();
`endif

        // Reset during data bit 4 of 0xFF
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB + H) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check_eq("midrst_idle", 32'(busy), 0);
        rises0 = valid_rises;
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_drain();
        check_eq("midrst_words", 32'(valid_rises - rises0), 1);

        repeat (10) @(negedge clk);
        check_eq("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, means clk cycles per UART bit; legal values are 8 to 65535.
REQ-002 Parameter DATA_BITS, default 8, means data bits per frame; legal values are 5 to 9.
REQ-003 Parameter STOP_BITS, default 1, means stop bits checked per frame; legal values are 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0, selects parity sense (0 even, 1 odd) and is used only when UART_RX_PARITY_EN is defined.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  DATA_BITS  last received word, LSB = first data bit.
REQ-009 rx_valid  output  1  rx_data and error flags are valid.
REQ-010 rx_ready  input  1  consumer accepts the word when rx_valid&&rx_ready.
REQ-011 frame_err  output  1  a stop bit was sampled low; qualified by rx_valid.
REQ-012 parity_err  output  1  parity mismatch; qualified by rx_valid.
REQ-013 overrun  output  1  one-cycle pulse when an unaccepted word is overwritten.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchroniser with reset value 1; all logic SHALL use only the synchronised value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE, a 1-to-0 transition of the synchronised rx SHALL enter START and clear the bit counter and the cycle counter.
REQ-018 Each bit SHALL be decided by a majority vote of 3 samples taken at cycle offsets H-1, H and H+1 from bit start, where H = CLKS_PER_BIT/2 (truncated).
REQ-019 In START, a voted 1 SHALL be treated as a false start and return the FSM to IDLE; no output changes and no flags are raised.
REQ-020 DATA SHALL shift in exactly DATA_BITS voted bits, LSB first, each CLKS_PER_BIT cycles apart.
REQ-021 After DATA, the FSM SHALL enter PARITY if UART_RX_PARITY_EN is defined, otherwise STOP.
REQ-022 STOP SHALL vote STOP_BITS stop bits; frame_err SHALL be the OR of all stop bits voted 0.
REQ-023 Word completion SHALL occur at the H+1 sample of the last stop bit; the FSM SHALL return to IDLE on the next cycle without waiting for the remainder of the bit time.
REQ-024 On the cycle after completion, rx_data, frame_err and parity_err SHALL update and rx_valid SHALL be 1.
REQ-025 rx_valid SHALL stay 1 until a cycle in which rx_ready is 1, and SHALL be 0 on the following cycle unless a new word completes in that same cycle.
REQ-026 If a word completes while rx_valid=1 and rx_ready=0, the new word SHALL overwrite the old one, rx_valid SHALL stay 1, and overrun SHALL pulse for one cycle.
REQ-027 If a word completes in the same cycle that rx_ready accepts the old word, the new word SHALL be loaded, rx_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-028 A line held at 0 SHALL produce one word with frame_err=1; the next frame SHALL NOT start until a 1-to-0 transition is seen in IDLE.

Reset
REQ-029 rst SHALL asynchronously force the FSM to IDLE, clear all counters, set the synchroniser to 11, and drive rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
REQ-030 When rst is asserted mid-frame, the partial word SHALL be discarded; after release, the FSM SHALL wait for a fresh falling edge.

Configuration
REQ-031 Macro UART_RX_PARITY_EN: when defined, one parity bit SHALL be received after the data bits, and parity_err SHALL be set when the XOR of the data bits, the parity bit and PARITY_ODD is 1.
REQ-032 When UART_RX_PARITY_EN is not defined, the PARITY state and its logic SHALL be absent, and parity_err SHALL be tied to 0.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-033 Send 0xA5 with rx_ready=1 -> rx_valid high for exactly 1 cycle, rx_data=0xA5, frame_err=0, and rx_valid rises 1 cycle after the H+1 sample of the stop bit.
REQ-034 Drive a 0-pulse of 5 cycles on an idle line -> START is entered, the false start returns to IDLE, and rx_valid stays 0.
REQ-035 Send 0x3C with its stop bit 0 -> rx_data=0x3C and frame_err=1; send a following 0x00 -> frame_err=0.
REQ-036 Hold rx_ready=0 and send 0x11 then 0x22 -> overrun pulses once and rx_data=0x22; raising rx_ready then gives one handshake.
REQ-037 With UART_RX_PARITY_EN defined and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1; repeat with parity bit 1 -> parity_err=0.
REQ-038 Assert rst at data bit 4 of 0xFF, release it, then send 0x5A -> outputs are at reset values during rst, then one word 0x5A is received with no errors.
